// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Widths, the NOP word and the fetch FSM encoding live here.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // One IF/ID payload: {pc, pc_plus4, instr}
  localparam int IFID_W = 2 * ADDR_W + INSTR_W;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    SKID    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding register for one fetched {pc, pc_plus4, instr} payload.
// Clear wins over load, load wins over unload.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [IFID_W-1:0] load_data,
  output logic [IFID_W-1:0] data,
  output logic              full
);

  logic [IFID_W-1:0] data_reg;
  logic              full_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      data_reg <= load_data;
      full_reg <= 1'b1;
    end else if (unload) begin
      full_reg <= 1'b0;
    end
  end

  assign data = data_reg;
  assign full = full_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// registers each fetched word into IF/ID, using a one-entry skid when decode stalls.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_INC   = 32'd4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus4,
  output logic [INSTR_W-1:0] ifid_instr
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] target_reg, target_next;
  logic              started_reg;
  logic              valid_reg, valid_next;
  logic [IFID_W-1:0] ifid_data_reg, ifid_data_next;

  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [IFID_W-1:0] skid_data;

  logic [ADDR_W-1:0] pc_plus_inc;
  logic [IFID_W-1:0] fetch_word;
  logic              ack_seen;
  logic              ifid_free;

  assign pc_plus_inc = pc_reg + PC_INC;
  assign fetch_word  = {pc_reg, pc_plus_inc, imem_rdata};
  assign ifid_free   = !valid_reg || !id_stall;

  // started_reg keeps the request low until the first edge after reset release
  assign imem_req  = started_reg && (state_reg != SKID);
  assign imem_addr = pc_reg;
  assign ack_seen  = imem_req && imem_ack;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      target_reg    <= RESET_PC;
      started_reg   <= 1'b0;
      valid_reg     <= 1'b0;
      ifid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      target_reg    <= target_next;
      started_reg   <= 1'b1;
      valid_reg     <= valid_next;
      ifid_data_reg <= ifid_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    target_next    = target_reg;
    valid_next     = valid_reg;
    ifid_data_next = ifid_data_reg;
    skid_load      = 1'b0;
    skid_unload    = 1'b0;
    skid_clear     = 1'b0;

    if (redirect) begin
      valid_next = 1'b0;
      skid_clear = 1'b0 | 1'b1;
      if (imem_req && !imem_ack) begin
        // An outstanding request cannot be abandoned: keep its address, park the target
        state_next  = DISCARD;
        target_next = redirect_pc;
      end else begin
        state_next = FETCH;
        pc_next    = redirect_pc;
      end
    end else begin
      if (ifid_free) begin
        valid_next = 1'b0;
      end
      unique case (state_reg)
        FETCH: begin
          if (ack_seen) begin
            pc_next = pc_plus_inc;
            if (ifid_free) begin
              ifid_data_next = fetch_word;
              valid_next     = 1'b1;
            end else begin
              skid_load  = 1'b1;
              state_next = SKID;
            end
          end
        end
        SKID: begin
          if (!id_stall) begin
            if (skid_full) begin
              ifid_data_next = skid_data;
              valid_next     = 1'b1;
            end
            skid_unload = 1'b1;
            state_next  = FETCH;
          end
        end
        DISCARD: begin
          if (ack_seen) begin
            pc_next    = target_reg;
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  fetch_skid_buffer u_skid (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (skid_clear),
    .load_data (fetch_word),
    .data      (skid_data),
    .full      (skid_full)
  );

  assign ifid_valid    = valid_reg;
  assign ifid_pc       = ifid_data_reg[IFID_W-1 -: ADDR_W];
  assign ifid_pc_plus4 = ifid_data_reg[INSTR_W +: ADDR_W];
  assign ifid_instr    = ifid_data_reg[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// scored against an in-order instruction-stream model.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;

  logic        zero_wait;
  logic        ack_drv;

  // second instance exercises address wrap from a high reset PC
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_stall = 1'b0;
  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_plus4, w_instr;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  // memory model: zero-wait mode acks every request; otherwise ack_drv gates it
  assign imem_ack   = imem_req & (zero_wait | ack_drv);
  assign imem_rdata = imem_addr ^ KEY;
  assign w_ack      = w_req;
  assign w_rdata    = w_addr ^ KEY;

  fetch_stage dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_stall      (id_stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .redirect      (w_redirect),
    .redirect_pc   (w_redirect_pc),
    .id_stall      (w_stall),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_ack),
    .imem_rdata    (w_rdata),
    .ifid_valid    (w_valid),
    .ifid_pc       (w_pc),
    .ifid_pc_plus4 (w_plus4),
    .ifid_instr    (w_instr)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench 1 ns after an edge with reset just released; the next step() is edge E1
  task automatic do_reset();
    Rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    zero_wait = 1'b1; ack_drv = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
    zero_wait = 1'b1; ack_drv = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
    checks++; if ({ifid_pc, ifid_pc_plus4, ifid_instr} !== 96'h0) begin errors++; $display("FAIL reset_ifid got %h %h %h want zeros", ifid_pc, ifid_pc_plus4, ifid_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 00000000", imem_addr); end
    checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr_wrap got %h want fffffff8", w_addr); end
    Rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || ifid_valid !== 1'b0) begin errors++; $display("FAIL first_edge got req=%b valid=%b want req=1 valid=0", imem_req, ifid_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset();
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      exp = 32'(4 * k);
      checks++;
      if (ifid_valid !== 1'b1 || ifid_pc !== exp || ifid_pc_plus4 !== exp + 32'd4 || ifid_instr !== (exp ^ KEY)) begin
        errors++;
        $display("FAIL seq_%0d got v=%b pc=%h p4=%h in=%h want v=1 pc=%h p4=%h in=%h",
                 k, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, exp, exp + 32'd4, exp ^ KEY);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (4) step();
    checks++; if (ifid_pc !== 32'h8 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_pre got pc=%h v=%b want pc=00000008 v=1", ifid_pc, ifid_valid); end
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ifid_pc !== 32'h8 || ifid_instr !== (32'h8 ^ KEY) || ifid_valid !== 1'b1 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d got pc=%h in=%h v=%b req=%b want pc=00000008 v=1 req=0", i, ifid_pc, ifid_instr, ifid_valid, imem_req);
      end
    end
    id_stall = 1'b0;
    step();
    checks++; if (ifid_pc !== 32'hC || ifid_instr !== (32'hC ^ KEY) || imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_release got pc=%h in=%h req=%b addr=%h want pc=0000000c req=1 addr=00000010", ifid_pc, ifid_instr, imem_req, imem_addr); end
    step();
    checks++; if (ifid_pc !== 32'h10 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_after got pc=%h v=%b want pc=00000010 v=1", ifid_pc, ifid_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    repeat (5) step();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL rdw_pre got addr=%h want 00000010", imem_addr); end
    zero_wait = 1'b0; ack_drv = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_addr !== 32'h10 || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin
        errors++;
        $display("FAIL rdw_hold_%0d got addr=%h req=%b v=%b want addr=00000010 req=1 v=0", i, imem_addr, imem_req, ifid_valid);
      end
      if (i < 2) step();
    end
    ack_drv = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h100 || ifid_valid !== 1'b0) begin errors++; $display("FAIL rdw_target got addr=%h v=%b want addr=00000100 v=0", imem_addr, ifid_valid); end
    zero_wait = 1'b1; ack_drv = 1'b0;
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_instr !== (32'h100 ^ KEY)) begin errors++; $display("FAIL rdw_first got v=%b pc=%h in=%h want v=1 pc=00000100", ifid_valid, ifid_pc, ifid_instr); end
  endtask

  task automatic test_redirect_ack_skid();
    do_reset();
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL rda_next got v=%b addr=%h req=%b want v=0 addr=00000200 req=1", ifid_valid, imem_addr, imem_req); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_instr !== (32'h200 ^ KEY)) begin errors++; $display("FAIL rda_first got v=%b pc=%h in=%h want v=1 pc=00000200", ifid_valid, ifid_pc, ifid_instr); end
    id_stall = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rds_skid got req=%b want 0", imem_req); end
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0; id_stall = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL rds_next got v=%b req=%b addr=%h want v=0 req=1 addr=00000300", ifid_valid, imem_req, imem_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h300) begin errors++; $display("FAIL rds_first got v=%b pc=%h want v=1 pc=00000300", ifid_valid, ifid_pc); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h304) begin errors++; $display("FAIL rds_second got v=%b pc=%h want v=1 pc=00000304", ifid_valid, ifid_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    step();
    checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFF8 || w_plus4 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_0 got v=%b pc=%h p4=%h want pc=fffffff8 p4=fffffffc", w_valid, w_pc, w_plus4); end
    step();
    checks++; if (w_pc !== 32'hFFFF_FFFC || w_plus4 !== 32'h0 || w_instr !== (32'hFFFF_FFFC ^ KEY)) begin errors++; $display("FAIL wrap_1 got pc=%h p4=%h in=%h want pc=fffffffc p4=00000000", w_pc, w_plus4, w_instr); end
    step();
    checks++; if (w_pc !== 32'h0 || w_plus4 !== 32'h4) begin errors++; $display("FAIL wrap_2 got pc=%h p4=%h want pc=00000000 p4=00000004", w_pc, w_plus4); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) step();
    zero_wait = 1'b0; ack_drv = 1'b0; id_stall = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rstm_pre got req=%b v=%b want req=1 v=1", imem_req, ifid_valid); end
    #3 Rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rstm_req got req=%b v=%b pc=%h in=%h addr=%h want all zero", imem_req, ifid_valid, ifid_pc, ifid_instr, imem_addr); end
    step();
    Rst_n = 1'b1; zero_wait = 1'b1; id_stall = 1'b0;
    repeat (3) step();
    id_stall = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rstm_skid_pre got req=%b v=%b want req=0 v=1", imem_req, ifid_valid); end
    #3 Rst_n = 1'b0;
    #1;
    checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rstm_skid got v=%b pc=%h p4=%h req=%b want all zero", ifid_valid, ifid_pc, ifid_pc_plus4, imem_req); end
    step();
    Rst_n = 1'b1; id_stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rstm_refetch got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0) begin errors++; $display("FAIL rstm_first got v=%b pc=%h want v=1 pc=00000000", ifid_valid, ifid_pc); end
  endtask

  // Decode sees an in-order stream: each consumed word is the next address of the
  // current path, and a redirect restarts the path at its target.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_pending;
    logic        stall_c, redir_c;
    logic [31:0] rpc;
    int          consumed;
    do_reset();
    zero_wait = 1'b0;
    step();
    exp_pc = 32'h0; prev_pending = 1'b0; prev_addr = 32'h0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_pending) begin
        checks++;
        if (imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_addr_hold cyc=%0d got %h want %h", cyc, imem_addr, prev_addr); end
      end
      stall_c = ($urandom_range(0, 3) == 0);
      redir_c = ($urandom_range(0, 15) == 0);
      rpc     = 32'($urandom_range(0, 16383)) << 2;
      id_stall = stall_c; redirect = redir_c; redirect_pc = rpc;
      ack_drv = ($urandom_range(0, 2) != 0);
      #1;
      if (ifid_valid && !stall_c && !redir_c) begin
        checks++;
        if (ifid_pc !== exp_pc || ifid_pc_plus4 !== exp_pc + 32'd4 || ifid_instr !== (exp_pc ^ KEY)) begin
          errors++;
          $display("FAIL rnd_stream cyc=%0d got pc=%h p4=%h in=%h want pc=%h p4=%h in=%h",
                   cyc, ifid_pc, ifid_pc_plus4, ifid_instr, exp_pc, exp_pc + 32'd4, exp_pc ^ KEY);
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redir_c) exp_pc = rpc;
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
      step();
    end
    redirect = 1'b0; id_stall = 1'b0;
    checks++;
    if (consumed < 200) begin errors++; $display("FAIL rnd_progress got %0d consumed want >= 200", consumed); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_ack_skid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the 32-bit PC-select mux and the IF/ID boundary.
- Owns the program counter and drives a request/acknowledge handshake to instruction memory.
- Buffers each fetched word (one skid entry) and presents PC, PC+4 and instruction to decode.
- Its ifid_pc_plus4 output feeds inA of the PC-select mux; redirect/redirect_pc carry the branch/jump path (the mux's inB/sel equivalent).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, byte increment between sequential fetches.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  reset, asynchronous assert, active-low.
- redirect  in  1  one-cycle pulse: taken branch/jump, flush and refetch.
- redirect_pc  in  32  target address, valid when redirect=1.
- id_stall  in  1  decode cannot accept; hold IF/ID outputs.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; held stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  request completes this cycle; imem_rdata valid.
- imem_rdata  in  32  instruction word.
- ifid_valid  out  1  IF/ID holds a valid instruction.
- ifid_pc  out  32  address of ifid_instr.
- ifid_pc_plus4  out  32  ifid_pc + PC_INC, mod 2^32.
- ifid_instr  out  32  fetched instruction.

Behaviour:
- Reset (Rst_n=0, async):
  - pc=RESET_PC; state=FETCH; ifid_valid=0.
  - ifid_pc, ifid_pc_plus4, ifid_instr = 0; skid entry empty.
  - imem_req=0 while in reset; rises on the first Clk edge after Rst_n deasserts.
- Addressing:
  - imem_addr is always the internal pc (registered).
  - pc+PC_INC wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- States:
  - FETCH: imem_req=1. On imem_ack, pc advances by PC_INC. Data goes to IF/ID if IF/ID is free (ifid_valid=0 or id_stall=0); stay in FETCH. Otherwise data goes to skid; go to SKID.
  - SKID: imem_req=0. When id_stall=0: skid -> IF/ID; go to FETCH; next request issues the following cycle.
  - DISCARD: imem_req=1 with the old address held (handshake cannot be abandoned). On imem_ack: rdata dropped; pc=saved redirect target; go to FETCH.
- Latency: imem_ack in cycle t -> ifid_valid=1 with that word in cycle t+1.
  - With zero-wait memory (ack same cycle as req) and no stalls, one instruction per cycle.
- id_stall=1 with ifid_valid=1: all ifid_* outputs hold unchanged.
- Redirect: highest priority over ack, stall and skid.
  - At the next edge: ifid_valid=0, skid cleared, pc=redirect_pc.
  - If imem_req=1 and imem_ack=0 that cycle: save target, go to DISCARD.
  - If imem_ack=1 that cycle: drop rdata; go to FETCH at redirect_pc.
  - From SKID: go to FETCH at redirect_pc.
  - A redirect while in DISCARD overwrites the saved target.
- Simultaneous id_stall=0 and imem_ack in SKID: skid -> IF/ID. imem_req is 0 in SKID, so a legal memory never acks there; an ack in SKID is ignored.
- Reset mid-request: all state cleared immediately. Memory must tolerate an abandoned request on reset only.

Decomposition:
- Shared package (cpu_pkg):
  - fetch-state enum FETCH/SKID/DISCARD.
  - INSTR_W=32, ADDR_W=32, NOP=32'h0000_0000.
- One sub-module: fetch_skid_buffer, a single-entry 96-bit {pc, pc_plus4, instr} holding register with load/unload/clear.
- PC register, FSM and output register stay in fetch_stage.

Test Plan:
- Reset, zero-wait memory (ack=req, rdata=addr^32'hA5A5_0000), no stalls -> ifid_pc 0,4,8,12 on consecutive cycles; ifid_pc_plus4 = ifid_pc+4; ifid_valid=1 from the second cycle after reset release.
- id_stall high for 3 cycles while ifid_pc=8 -> ifid outputs hold 8; word at 12 lands in skid; imem_req=0. Stall drop -> ifid_pc=12 next cycle, then fetch of 16.
- Redirect to 32'h0000_0100 while a request to 0x10 waits 3 cycles -> imem_addr holds 0x10 until ack; that word never appears; next imem_addr=0x100; first valid ifid_pc=0x100.
- Redirect in the same cycle as ack, and redirect while in SKID -> ifid_valid=0 next cycle; skid empty; next fetch at redirect_pc.
- RESET_PC=32'hFFFF_FFF8 -> sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; ifid_pc_plus4 of FFFF_FFFC is 0.
- Rst_n low mid-request and during SKID -> outputs zero immediately (async); refetch at RESET_PC after release.
